// File: rtl/queue_prog_pkg.sv
// ============================================================================
// Module      : queue_prog_pkg
// Description : Shared constants and helpers for the queue_prog FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package queue_prog_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic bit params_legal(input int ae_level, input int af_level, input int depth);
        return (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/queue_prog_if.sv
// ============================================================================
// Module      : queue_prog_if
// Description : Push/pop/status bundle between a producer-consumer and the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface queue_prog_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  flush_IN;
    logic                  pushReq_IN;
    logic [DATA_WIDTH-1:0] data_IN;
    logic                  popReq_IN;
    logic [DATA_WIDTH-1:0] data_OUT;
    logic                  popValid_OUT;
    logic                  emptyFlag_OUT;
    logic                  fullFlag_OUT;
    logic                  almostFull_OUT;
    logic                  almostEmpty_OUT;
    logic [ADDR_WIDTH:0]   count_OUT;
    logic                  overflow_OUT;
    logic                  underflow_OUT;

    modport master (
        output flush_IN, pushReq_IN, data_IN, popReq_IN,
        input  data_OUT, popValid_OUT, emptyFlag_OUT, fullFlag_OUT,
               almostFull_OUT, almostEmpty_OUT, count_OUT, overflow_OUT, underflow_OUT
    );

    modport slave (
        input  flush_IN, pushReq_IN, data_IN, popReq_IN,
        output data_OUT, popValid_OUT, emptyFlag_OUT, fullFlag_OUT,
               almostFull_OUT, almostEmpty_OUT, count_OUT, overflow_OUT, underflow_OUT
    );
endinterface

`default_nettype wire

// File: rtl/queue_prog_mem.sv
// ============================================================================
// Module      : queue_mem
// Description : DEPTH x DATA_WIDTH register array, sync write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output      logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [(1 << ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

`default_nettype wire

// File: rtl/queue_prog.sv
// ============================================================================
// Module      : queue_prog
// Description : Circular FIFO, standard or FWFT output, programmable flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_prog
    import queue_prog_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int FWFT       = MODE_STD,
    parameter int AF_LEVEL   = depth_of(ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    queue_prog_if.slave  bus
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_af      = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   c_ae      = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    if (!params_legal(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_bad_params
        $error("queue_prog: parameters must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_acc;
    logic                  w_push_acc;
    logic                  w_bypass;
    logic                  w_push_drop;
    logic                  w_pop_drop;
    logic [DATA_WIDTH-1:0] w_head_data;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_depth);
    // Flush masks every request, so nothing it overlaps can move state or raise errors.
    assign w_pop_acc   = bus.popReq_IN && !w_empty && !bus.flush_IN;
    assign w_bypass    = (FWFT == MODE_STD) && w_empty && bus.pushReq_IN
                         && bus.popReq_IN && !bus.flush_IN;
    assign w_push_acc  = bus.pushReq_IN && (!w_full || w_pop_acc) && !w_bypass && !bus.flush_IN;
    assign w_push_drop = bus.pushReq_IN && w_full && !w_pop_acc && !bus.flush_IN;
    assign w_pop_drop  = bus.popReq_IN && w_empty && !w_bypass && !bus.flush_IN;

    queue_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push_acc),
        .i_waddr (r_tail),
        .i_wdata (bus.data_IN),
        .i_raddr (r_head),
        .o_rdata (w_head_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush_IN) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) r_tail <= r_tail + c_ptr_one;
            if (w_pop_acc)  r_head <= r_head + c_ptr_one;
            if (w_push_acc && !w_pop_acc)      r_count <= r_count + c_cnt_one;
            else if (!w_push_acc && w_pop_acc) r_count <= r_count - c_cnt_one;
            if (w_push_drop) r_overflow  <= 1'b1;
            if (w_pop_drop)  r_underflow <= 1'b1;
        end
    end

    if (FWFT == MODE_STD) begin : g_std
        logic [DATA_WIDTH-1:0] r_data_out;
        logic                  r_pop_valid;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_data_out  <= '0;
                r_pop_valid <= 1'b0;
            end else if (bus.flush_IN) begin
                r_pop_valid <= 1'b0;
            end else if (w_bypass) begin
                r_data_out  <= bus.data_IN;
                r_pop_valid <= 1'b1;
            end else if (w_pop_acc) begin
                r_data_out  <= w_head_data;
                r_pop_valid <= 1'b1;
            end else begin
                r_pop_valid <= 1'b0;
            end
        end

        assign bus.data_OUT     = r_data_out;
        assign bus.popValid_OUT = r_pop_valid;
    end else begin : g_fwft
        assign bus.data_OUT     = w_head_data;
        assign bus.popValid_OUT = !w_empty;
    end

    assign bus.emptyFlag_OUT   = w_empty;
    assign bus.fullFlag_OUT    = w_full;
    assign bus.almostFull_OUT  = (r_count >= c_af);
    assign bus.almostEmpty_OUT = (r_count <= c_ae);
    assign bus.count_OUT       = r_count;
    assign bus.overflow_OUT    = r_overflow;
    assign bus.underflow_OUT   = r_underflow;
endmodule

`default_nettype wire
